cache_refill_ctrl: RTL and testbench
====================================

# cache_refill_ctrl

Miss-handling stage that sits directly downstream of the 4-way set-associative lookup. When the lookup reports a miss, this block writes back the selected victim line if it is dirty, then fetches the requested line from main memory one word at a time. It writes the new line into the chosen way of the cache array and returns the requested word to the requester. It handles one miss at a time.

## Interface
- TAG_BITS, 18, tag width
- INDEX_BITS, 8, set index width (256 sets)
- OFFSET_BITS, 6, byte offset width (64-byte line)
- DATA_WIDTH, 32, memory/response word width
- WAYS, 4, associativity; way select width is log2(WAYS)
- Derived: LINE_BITS = 8<<OFFSET_BITS (512); WORDS = LINE_BITS/DATA_WIDTH (16); ADDR_WIDTH = TAG_BITS+INDEX_BITS+OFFSET_BITS (32)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- i_miss_valid  in  1  miss request from lookup stage
- o_miss_ready  out  1  high only in IDLE
- i_tag / i_index / i_offset  in  TAG_BITS / INDEX_BITS / OFFSET_BITS  missing address
- i_victim_way  in  log2(WAYS)  way chosen by LRU for replacement
- i_victim_dirty  in  1  victim dirty bit
- i_victim_tag  in  TAG_BITS  victim tag
- i_victim_line  in  LINE_BITS  victim data, word k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_mem_req  out  1  memory request
- o_mem_we  out  1  1 = write, 0 = read
- o_mem_addr  out  ADDR_WIDTH  word-aligned byte address
- o_mem_wdata  out  DATA_WIDTH  write data
- i_mem_ack  in  1  memory accepted/completed current word
- i_mem_rdata  in  DATA_WIDTH  read data, valid with i_mem_ack on reads
- o_fill_valid  out  1  one-cycle cache array write strobe
- o_fill_way / o_fill_index / o_fill_tag  out  log2(WAYS) / INDEX_BITS / TAG_BITS  fill target
- o_fill_line  out  LINE_BITS  new line data; array sets valid=1, dirty=0
- o_resp_valid  out  1  requested word available
- o_resp_data  out  DATA_WIDTH  requested word
- i_resp_ready  in  1  requester consumes response

## Operation
- A request is accepted when i_miss_valid && o_miss_ready at a rising edge. At that edge the block captures tag, index, offset, victim way, dirty bit, tag and line. Inputs are don't-care afterwards.
- The state machine has five states: IDLE, WB, FILL, UPDATE, RESP.
  - IDLE: on accept, go to WB if the victim is dirty, otherwise go to FILL.
  - WB: write words 0..WORDS-1 in ascending order. Address is {victim_tag, index, k, 2'b00}; data is victim word k. After the ack for word WORDS-1, go to FILL.
  - FILL: read words 0..WORDS-1 in ascending order from {tag, index, k, 2'b00}. Store i_mem_rdata into line buffer slot k when acked. After the ack for word WORDS-1, go to UPDATE.
  - UPDATE: o_fill_valid=1 for exactly one cycle with the captured way/index/tag and the buffered line. Then go to RESP.
  - RESP: o_resp_valid=1 and o_resp_data = buffer word offset[OFFSET_BITS-1:2]; offset[1:0] is ignored. Go to IDLE at the edge where i_resp_ready=1.
- Memory handshake:
  - While in WB or FILL, o_mem_req=1 and addr/we/wdata stay stable until an edge with i_mem_ack=1.
  - At that edge the word counter advances. o_mem_req stays high with the next address, so back-to-back words are possible.
  - o_mem_req drops in the cycle after the last ack.
  - i_mem_ack while o_mem_req=0 is ignored.
- The word counter is log2(WORDS) bits and is cleared on each entry to WB and to FILL. The last word is detected as counter == WORDS-1, with no wrap into extra requests.
- Critical-word-first is not supported: the response is always given after the full line is filled.

## Timing
- Reset (asynchronous, rst=0) forces:
  - state IDLE, o_miss_ready=1
  - o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0
  - o_fill_valid=0, o_resp_valid=0, o_resp_data=0
  - all fill outputs 0, counter 0
- Reset mid-burst abandons the miss. No fill strobe and no response are produced. Partial memory writes already done are not undone.
- Clean miss with i_mem_ack held at 1:
  - accept at edge E0; read requests in cycles E0..E15; last ack at E16
  - o_fill_valid high in the cycle after E16
  - o_resp_valid high from the cycle after E17, which is 18 cycles after accept
- Dirty miss adds 16 cycles: o_resp_valid is high 34 cycles after accept.
- o_miss_ready is low from the cycle after accept until the cycle after the response handshake. A new accept is possible at earliest one cycle after the resp handshake edge.
- o_resp_valid and o_resp_data hold stable while i_resp_ready=0.
- o_mem_we is 1 only in WB.

## Test plan
- Clean miss, tag 0x2A5F1, index 0x3C, offset 0x24, way 2, ack always 1, memory returns word k = 0xA000_0000+k.
  - Required: 16 reads at 0x.. addresses stepping by 4; fill strobe once with way 2; o_resp_data = 0xA000_0009; resp valid 18 cycles after accept.
- Dirty miss, victim tag 0x00011, victim word k = 0x5500_0000+k.
  - Required: 16 writes to {0x00011, index, k, 00} with matching data before any read; resp valid 34 cycles after accept.
- Memory stalls: ack only every 3rd cycle.
  - Required: addr/wdata stable during the stall; exactly WORDS acks consumed per phase; fill line is correct.
- Hold i_resp_ready=0 for 5 cycles, and assert i_miss_valid throughout.
  - Required: response stable; o_miss_ready=0; second miss accepted only after the handshake.
- Assert rst=0 mid-FILL at word 7.
  - Required: outputs go to reset values immediately; no o_fill_valid; the next miss completes normally.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss handler that writes back a dirty victim, refills the line word by word,
// writes it into the cache array and returns the requested word.
module cache_refill_ctrl #(
    parameter int TAG_BITS    = 18,
    parameter int INDEX_BITS  = 8,
    parameter int OFFSET_BITS = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int WAYS        = 4,
    localparam int WAY_BITS   = $clog2(WAYS),
    localparam int LINE_BITS  = 8 << OFFSET_BITS,
    localparam int WORDS      = LINE_BITS / DATA_WIDTH,
    localparam int CNT_BITS   = $clog2(WORDS),
    localparam int BYTE_BITS  = OFFSET_BITS - CNT_BITS,
    localparam int ADDR_WIDTH = TAG_BITS + INDEX_BITS + OFFSET_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_miss_valid,
    output logic                  o_miss_ready,
    input  logic [TAG_BITS-1:0]   i_tag,
    input  logic [INDEX_BITS-1:0] i_index,
    input  logic [OFFSET_BITS-1:0] i_offset,
    input  logic [WAY_BITS-1:0]   i_victim_way,
    input  logic                  i_victim_dirty,
    input  logic [TAG_BITS-1:0]   i_victim_tag,
    input  logic [LINE_BITS-1:0]  i_victim_line,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_fill_valid,
    output logic [WAY_BITS-1:0]   o_fill_way,
    output logic [INDEX_BITS-1:0] o_fill_index,
    output logic [TAG_BITS-1:0]   o_fill_tag,
    output logic [LINE_BITS-1:0]  o_fill_line,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_resp_data,
    input  logic                  i_resp_ready
);
    typedef enum logic [2:0] {IDLE, WB, FILL, UPDATE, RESP} state_t;
    state_t state, state_nx;
    logic [TAG_BITS-1:0]   tag_q, vtag_q;
    logic [INDEX_BITS-1:0] index_q;
    logic [CNT_BITS-1:0]   word_q, cnt;
    logic [WAY_BITS-1:0]   way_q;
    logic [LINE_BITS-1:0]  vline_q, line_q;
    logic accept, fire, last, unused_byte;

    assign o_miss_ready = state == IDLE;
    assign accept       = i_miss_valid && o_miss_ready;
    assign o_mem_req    = state == WB || state == FILL;
    assign o_mem_we     = state == WB;
    assign fire         = o_mem_req && i_mem_ack;
    assign last         = cnt == CNT_BITS'(WORDS - 1);
    assign unused_byte  = ^i_offset[BYTE_BITS-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tag_q   <= '0;
            vtag_q  <= '0;
            index_q <= '0;
            word_q  <= '0;
            way_q   <= '0;
            vline_q <= '0;
            line_q  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (accept || (fire && last)) ? '0 : cnt + CNT_BITS'(fire);
            if (accept) begin
                tag_q   <= i_tag;
                vtag_q  <= i_victim_tag;
                index_q <= i_index;
                word_q  <= i_offset[OFFSET_BITS-1 -: CNT_BITS];
                way_q   <= i_victim_way;
                vline_q <= i_victim_line;
            end
            if (state == FILL && fire)
                line_q[cnt*DATA_WIDTH +: DATA_WIDTH] <= i_mem_rdata;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (i_victim_dirty ? WB : FILL) : IDLE;
            WB:      state_nx = (fire && last) ? FILL : WB;
            FILL:    state_nx = (fire && last) ? UPDATE : FILL;
            UPDATE:  state_nx = RESP;
            RESP:    state_nx = i_resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Everything below is gated by state so idle/reset outputs read as zero.
    assign o_mem_addr   = o_mem_we ? {vtag_q, index_q, cnt, {BYTE_BITS{1'b0}}} :
                          state == FILL ? {tag_q, index_q, cnt, {BYTE_BITS{1'b0}}} : '0;
    assign o_mem_wdata  = o_mem_we ? vline_q[cnt*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign o_fill_valid = state == UPDATE;
    assign o_fill_way   = o_fill_valid ? way_q : '0;
    assign o_fill_index = o_fill_valid ? index_q : '0;
    assign o_fill_tag   = o_fill_valid ? tag_q : '0;
    assign o_fill_line  = o_fill_valid ? line_q : '0;
    assign o_resp_valid = state == RESP;
    assign o_resp_data  = o_resp_valid ? line_q[word_q*DATA_WIDTH +: DATA_WIDTH] : '0;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: randomized scenarios against a transaction-level memory model;
// expected bus traffic, fill line and response word are derived from the miss parameters.
module tb_cache_refill_ctrl;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic clk, rst, i_miss_valid, o_miss_ready, i_victim_dirty;
    logic [17:0] i_tag, i_victim_tag, o_fill_tag;
    logic [7:0] i_index, o_fill_index;
    logic [5:0] i_offset;
    logic [1:0] i_victim_way, o_fill_way;
    logic [511:0] i_victim_line, o_fill_line;
    logic o_mem_req, o_mem_we, i_mem_ack, o_fill_valid, o_resp_valid, i_resp_ready;
    logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata, o_resp_data;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .i_miss_valid(i_miss_valid), .o_miss_ready(o_miss_ready),
        .i_tag(i_tag), .i_index(i_index), .i_offset(i_offset),
        .i_victim_way(i_victim_way), .i_victim_dirty(i_victim_dirty),
        .i_victim_tag(i_victim_tag), .i_victim_line(i_victim_line),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_fill_valid(o_fill_valid), .o_fill_way(o_fill_way), .o_fill_index(o_fill_index),
        .o_fill_tag(o_fill_tag), .o_fill_line(o_fill_line),
        .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data), .i_resp_ready(i_resp_ready)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int checks = 0, passes = 0;
    int ack_mode = 0, phase = 0, stall_viol = 0, fill_cnt = 0;
    logic [31:0] mem [logic [31:0]];
    txn_t obs_q[$], exp_q[$];
    logic [1:0] f_way;
    logic [7:0] f_idx;
    logic [17:0] f_tag;
    logic [511:0] f_line;

    logic [17:0] m_tag, m_vtag;
    logic [7:0] m_idx;
    logic [5:0] m_off;
    logic [1:0] m_way;
    logic m_dirty;
    logic [511:0] m_vline, exp_line;
    logic [31:0] exp_word;

    function automatic logic [31:0] mem_val(logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic bit traffic_ok();
        if (obs_q.size() != exp_q.size()) return 0;
        foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) return 0;
        return 1;
    endfunction

    // Memory slave: records every accepted word and applies writes to the model.
    initial begin
        bit p_req = 0, p_ack = 0, p_we = 0;
        logic [31:0] p_addr = 0, p_wd = 0, p_rd = 0;
        i_mem_ack = 0;
        i_mem_rdata = 0;
        forever begin
            @(negedge clk);
            if (rst && p_req && p_ack) begin
                obs_q.push_back({p_we, p_addr, p_we ? p_wd : p_rd});
                if (p_we) mem[p_addr] = p_wd;
            end
            if (rst && p_req && !p_ack && o_mem_req &&
                {o_mem_we, o_mem_addr, o_mem_wdata} !== {p_we, p_addr, p_wd}) stall_viol++;
            phase++;
            i_mem_ack = ack_mode == 0 ? 1'b1 : ack_mode == 1 ? (phase % 3 == 0) : 1'($urandom_range(0, 1));
            i_mem_rdata = mem_val(o_mem_addr);
            p_req = o_mem_req; p_ack = i_mem_ack; p_we = o_mem_we;
            p_addr = o_mem_addr; p_wd = o_mem_wdata; p_rd = i_mem_rdata;
        end
    end

    initial forever begin
        @(negedge clk);
        if (o_fill_valid) begin
            fill_cnt++;
            f_way = o_fill_way; f_idx = o_fill_index; f_tag = o_fill_tag; f_line = o_fill_line;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic rand_miss();
        logic [31:0] r;
        r = $urandom; m_tag = r[17:0];
        r = $urandom; m_idx = r[7:0]; m_off = r[13:8]; m_way = r[17:16]; m_dirty = r[20];
        r = $urandom; m_vtag = r[17:0];
        if (m_vtag == m_tag) m_vtag[0] = ~m_vtag[0];
        for (int k = 0; k < 16; k++) m_vline[k*32 +: 32] = $urandom;
    endtask

    task automatic build_exp();
        logic [31:0] a;
        exp_q.delete();
        if (m_dirty)
            for (int k = 0; k < 16; k++)
                exp_q.push_back({1'b1, m_vtag, m_idx, 4'(k), 2'b00, m_vline[k*32 +: 32]});
        for (int k = 0; k < 16; k++) begin
            a = {m_tag, m_idx, 4'(k), 2'b00};
            exp_line[k*32 +: 32] = mem_val(a);
            exp_q.push_back({1'b0, a, mem_val(a)});
        end
        exp_word = exp_line[m_off[5:2]*32 +: 32];
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic start_miss(input bit hold);
        i_tag = m_tag; i_index = m_idx; i_offset = m_off; i_victim_way = m_way;
        i_victim_dirty = m_dirty; i_victim_tag = m_vtag; i_victim_line = m_vline;
        i_miss_valid = 1;
        build_exp();
        obs_q.delete();
        stall_viol = 0;
        @(posedge clk);
        @(negedge clk);
        i_tag = ~m_tag; i_offset = ~m_off; i_victim_tag = ~m_vtag; i_victim_line = ~m_vline;
        i_victim_way = ~m_way;
        if (!hold) i_miss_valid = 0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!o_resp_valid && lat < 2000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic consume();
        i_resp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        i_resp_ready = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        i_miss_valid = 1; i_resp_ready = 0;
        repeat (2) @(negedge clk);
        checks++; if (o_miss_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_miss_ready); else passes++;
        checks++; if ({o_mem_req, o_mem_we, o_fill_valid, o_resp_valid} !== 4'b0)
            $display("FAIL reset_strobes: got %b want 0000", {o_mem_req, o_mem_we, o_fill_valid, o_resp_valid}); else passes++;
        checks++; if ({o_mem_addr, o_mem_wdata, o_resp_data} !== 96'h0)
            $display("FAIL reset_data: got %h want 0", {o_mem_addr, o_mem_wdata, o_resp_data}); else passes++;
        checks++; if ({o_fill_way, o_fill_index, o_fill_tag} !== 28'h0 || o_fill_line !== '0)
            $display("FAIL reset_fill: got %h want 0", {o_fill_way, o_fill_index, o_fill_tag}); else passes++;
        i_miss_valid = 0;
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_clean_miss();
        int lat, f0;
        ack_mode = 0;
        rand_miss();
        m_tag = 18'h2A5F1; m_idx = 8'h3C; m_off = 6'h24; m_way = 2'd2; m_dirty = 0;
        for (int k = 0; k < 16; k++) mem[{m_tag, m_idx, 4'(k), 2'b00}] = 32'hA000_0000 + k;
        f0 = fill_cnt;
        start_miss(0);
        checks++; if (o_miss_ready !== 1'b0) $display("FAIL clean_busy: ready %b want 0", o_miss_ready); else passes++;
        wait_resp(lat);
        checks++; if (lat != 18) $display("FAIL clean_latency: got %0d want 18", lat); else passes++;
        checks++; if (o_resp_data !== 32'hA000_0009) $display("FAIL clean_resp: got %h want a0000009", o_resp_data); else passes++;
        checks++; if (fill_cnt != f0 + 1) $display("FAIL clean_fill_count: got %0d want %0d", fill_cnt - f0, 1); else passes++;
        checks++; if ({f_way, f_idx, f_tag} !== {2'd2, 8'h3C, 18'h2A5F1})
            $display("FAIL clean_fill_target: got %h want %h", {f_way, f_idx, f_tag}, {2'd2, 8'h3C, 18'h2A5F1}); else passes++;
        checks++; if (f_line !== exp_line) $display("FAIL clean_fill_line: got %h want %h", f_line, exp_line); else passes++;
        checks++; if (!traffic_ok()) $display("FAIL clean_traffic: got %0d txns want %0d", obs_q.size(), exp_q.size()); else passes++;
        consume();
        checks++; if ({o_resp_valid, o_miss_ready} !== 2'b01)
            $display("FAIL clean_release: got %b want 01", {o_resp_valid, o_miss_ready}); else passes++;
    endtask

    task automatic test_dirty_miss();
        int lat;
        ack_mode = 0;
        rand_miss();
        m_dirty = 1; m_vtag = 18'h00011;
        if (m_tag == m_vtag) m_tag[5] = ~m_tag[5];
        for (int k = 0; k < 16; k++) m_vline[k*32 +: 32] = 32'h5500_0000 + k;
        start_miss(0);
        wait_resp(lat);
        checks++; if (lat != 34) $display("FAIL dirty_latency: got %0d want 34", lat); else passes++;
        checks++; if (!traffic_ok()) $display("FAIL dirty_traffic: got %0d txns want %0d", obs_q.size(), exp_q.size()); else passes++;
        checks++; if (o_resp_data !== exp_word) $display("FAIL dirty_resp: got %h want %h", o_resp_data, exp_word); else passes++;
        checks++; if (f_line !== exp_line) $display("FAIL dirty_fill_line: got %h want %h", f_line, exp_line); else passes++;
        consume();
    endtask

    task automatic test_mem_stall();
        int lat;
        ack_mode = 1;
        rand_miss();
        m_dirty = 1;
        start_miss(0);
        wait_resp(lat);
        checks++; if (stall_viol != 0) $display("FAIL stall_stable: got %0d changes want 0", stall_viol); else passes++;
        checks++; if (!traffic_ok()) $display("FAIL stall_traffic: got %0d txns want %0d", obs_q.size(), exp_q.size()); else passes++;
        checks++; if (f_line !== exp_line) $display("FAIL stall_fill_line: got %h want %h", f_line, exp_line); else passes++;
        checks++; if (o_resp_data !== exp_word) $display("FAIL stall_resp: got %h want %h", o_resp_data, exp_word); else passes++;
        consume();
    endtask

    task automatic test_resp_hold();
        int lat;
        bit bad = 0;
        logic [31:0] held;
        ack_mode = 2;
        rand_miss();
        start_miss(1);
        wait_resp(lat);
        held = o_resp_data;
        checks++; if (held !== exp_word) $display("FAIL hold_resp: got %h want %h", held, exp_word); else passes++;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (o_resp_valid !== 1'b1 || o_resp_data !== held || o_miss_ready !== 1'b0) bad = 1;
        end
        checks++; if (bad) $display("FAIL hold_stable: got valid %b data %h ready %b want 1 %h 0",
            o_resp_valid, o_resp_data, o_miss_ready, held); else passes++;
        consume();
        checks++; if ({o_miss_ready, o_resp_valid, o_mem_req} !== 3'b100)
            $display("FAIL hold_release: got %b want 100", {o_miss_ready, o_resp_valid, o_mem_req}); else passes++;
        rand_miss();
        start_miss(0);
        checks++; if (o_miss_ready !== 1'b0) $display("FAIL hold_second_accept: ready %b want 0", o_miss_ready); else passes++;
        wait_resp(lat);
        checks++; if (o_resp_data !== exp_word) $display("FAIL hold_second_resp: got %h want %h", o_resp_data, exp_word); else passes++;
        checks++; if (!traffic_ok()) $display("FAIL hold_second_traffic: got %0d txns want %0d", obs_q.size(), exp_q.size()); else passes++;
        consume();
    endtask

    task automatic test_reset_mid_fill();
        int lat, f0;
        ack_mode = 0;
        rand_miss();
        m_dirty = 0;
        f0 = fill_cnt;
        start_miss(0);
        repeat (7) @(negedge clk);
        #2;
        checks++; if (o_mem_req !== 1'b1 || o_mem_addr !== {m_tag, m_idx, 4'd7, 2'b00})
            $display("FAIL midfill_word7: got req %b addr %h want 1 %h", o_mem_req, o_mem_addr, {m_tag, m_idx, 4'd7, 2'b00}); else passes++;
        rst = 0;
        #1;
        checks++; if ({o_miss_ready, o_mem_req, o_mem_we, o_fill_valid, o_resp_valid} !== 5'b10000)
            $display("FAIL midfill_reset_strobes: got %b want 10000", {o_miss_ready, o_mem_req, o_mem_we, o_fill_valid, o_resp_valid}); else passes++;
        checks++; if ({o_mem_addr, o_mem_wdata, o_resp_data} !== 96'h0)
            $display("FAIL midfill_reset_data: got %h want 0", {o_mem_addr, o_mem_wdata, o_resp_data}); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (fill_cnt != f0 || o_resp_valid !== 1'b0)
            $display("FAIL midfill_no_fill: got %0d fills resp %b want 0 0", fill_cnt - f0, o_resp_valid); else passes++;
        #2 rst = 1;
        @(negedge clk);
        rand_miss();
        f0 = fill_cnt;
        start_miss(0);
        wait_resp(lat);
        checks++; if (o_resp_data !== exp_word || fill_cnt != f0 + 1)
            $display("FAIL midfill_next_resp: got %h fills %0d want %h 1", o_resp_data, fill_cnt - f0, exp_word); else passes++;
        checks++; if (!traffic_ok() || f_line !== exp_line)
            $display("FAIL midfill_next_traffic: got %0d txns want %0d", obs_q.size(), exp_q.size()); else passes++;
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        ack_mode = 2;
        for (int n = 0; n < 4; n++) begin
            rand_miss();
            start_miss(0);
            wait_resp(lat);
            checks++; if (o_resp_data !== exp_word) $display("FAIL b2b_resp%0d: got %h want %h", n, o_resp_data, exp_word); else passes++;
            checks++; if (!traffic_ok() || f_line !== exp_line || {f_way, f_idx, f_tag} !== {m_way, m_idx, m_tag})
                $display("FAIL b2b_fill%0d: got %0d txns want %0d", n, obs_q.size(), exp_q.size()); else passes++;
            consume();
        end
    endtask

    initial begin
        rst = 0; i_miss_valid = 0; i_resp_ready = 0;
        i_tag = 0; i_index = 0; i_offset = 0; i_victim_way = 0;
        i_victim_dirty = 0; i_victim_tag = 0; i_victim_line = 0;
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_mem_stall();
        test_resp_hold();
        test_reset_mid_fill();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
